// File: rtl/multi_sync_filter_if.sv
// Level-input bundle for multi_sync_filter: raw inputs, debounced levels and edge pulses.
// With MULTI_SYNC_FILTER_STICKY_EN defined, the sticky event flags and their clears are carried as well.
interface multi_sync_filter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] din;
    logic [NUM_CH-1:0] dout;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
`ifdef MULTI_SYNC_FILTER_STICKY_EN
    logic [NUM_CH-1:0] evt_clr;
    logic [NUM_CH-1:0] rise_evt;
    logic [NUM_CH-1:0] fall_evt;

    modport master (output din, evt_clr, input dout, rise, fall, rise_evt, fall_evt);
    modport slave  (input din, evt_clr, output dout, rise, fall, rise_evt, fall_evt);
`else
    modport master (output din, input dout, rise, fall);
    modport slave  (input din, output dout, rise, fall);
`endif
endinterface

// File: rtl/multi_sync_filter.sv
// Per-channel synchronizer, stability filter and edge-pulse generator for asynchronous level inputs.
// Define MULTI_SYNC_FILTER_STICKY_EN to add sticky rise/fall event flags with per-channel clear.
module multi_sync_filter #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGE    = 3,
    parameter int FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               resetn,
    multi_sync_filter_if.slave bus
);
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [NUM_CH-1:0] dout_vec;
    logic [NUM_CH-1:0] rise_vec;
    logic [NUM_CH-1:0] fall_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;
        logic [CNT_W-1:0] cnt_q;
        logic             dout_q;
        logic             rise_q;
        logic             fall_q;
        logic             s;

        assign s = sync_q[SYNC_STAGE-1];

        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
        // shift chain and the counter/dout pair update together without ordering races.
        always_ff @(posedge clk) begin
            // NOTE: the synchronizer chain is reset like any other state so a reset mid-filter
            // cannot leave a stale level queued behind it to produce a phantom pulse.
            if (!resetn) begin
                sync_q <= '0;
                cnt_q  <= '0;
                dout_q <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGE-2:0], bus.din[i]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s == dout_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Pulses are registered alongside dout so they mark its first new cycle.
                    dout_q <= s;
                    cnt_q  <= '0;
                    rise_q <= s;
                    fall_q <= ~s;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign dout_vec[i] = dout_q;
        assign rise_vec[i] = rise_q;
        assign fall_vec[i] = fall_q;
    end

    assign bus.dout = dout_vec;
    assign bus.rise = rise_vec;
    assign bus.fall = fall_vec;

`ifdef MULTI_SYNC_FILTER_STICKY_EN
    logic [NUM_CH-1:0] rise_evt_q;
    logic [NUM_CH-1:0] fall_evt_q;

    // Set terms are OR-ed after the clear mask, so a pulse coinciding with a clear wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rise_evt_q <= '0;
            fall_evt_q <= '0;
        end else begin
            rise_evt_q <= rise_vec | (rise_evt_q & ~bus.evt_clr);
            fall_evt_q <= fall_vec | (fall_evt_q & ~bus.evt_clr);
        end
    end

    assign bus.rise_evt = rise_evt_q;
    assign bus.fall_evt = fall_evt_q;
`endif
endmodule
